// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU constants and opcode decoding for the ALU sharing arbiter and
// the main control decoder.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
    localparam logic [OP_W-1:0] OP_MUL = 4'b1001;
    localparam logic [OP_W-1:0] OP_DIV = 4'b1010;
    localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SLT, OP_MUL, OP_DIV, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win
// last time is granted. No grant is issued while reset is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (eligible == 2'b11) begin
                grant = last_grant_reg ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute path (requester 0) and the
// branch/compare helper (requester 1), with a one-deep response buffer each.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = alu_share_arbiter_pkg::DATA_W,
    parameter int OP_W   = alu_share_arbiter_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp0_zero,
    output logic              rsp1_zero,
    output logic              rsp0_err,
    output logic              rsp1_err
);

    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];
    logic [OP_W-1:0]   req_op [2];
    logic [1:0]        req_bad;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              sel;
    logic              pass_to_alu;

    logic [1:0]        rsp_valid_reg;
    logic [DATA_W-1:0] rsp_result_reg [2];
    logic [1:0]        rsp_zero_reg;
    logic [1:0]        rsp_err_reg;

    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // A buffer being drained this cycle is free for a new capture.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_bad[gi]  = !is_legal_op(req_op[gi]) ||
                              ((req_op[gi] == OP_DIV) && (req_b[gi] == '0));
        assign eligible[gi] = req_valid[gi] && (!rsp_valid_reg[gi] || rsp_ready[gi]);
    end

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready   = grant;
    assign sel         = grant[1];
    assign pass_to_alu = (|grant) && !req_bad[sel];

    // Faulting requests never reach the ALU; it sees an add of zeros instead.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        if (pass_to_alu) begin
            alu_a  = req_a[sel];
            alu_b  = req_b[sel];
            alu_op = req_op[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 2'b00;
            rsp_zero_reg  <= 2'b00;
            rsp_err_reg   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rsp_result_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid_reg[i] <= 1'b1;
                    if (req_bad[i]) begin
                        rsp_result_reg[i] <= '0;
                        rsp_zero_reg[i]   <= 1'b1;
                        rsp_err_reg[i]    <= 1'b1;
                    end else begin
                        rsp_result_reg[i] <= alu_result;
                        rsp_zero_reg[i]   <= alu_zero;
                        rsp_err_reg[i]    <= 1'b0;
                    end
                end else if (rsp_ready[i]) begin
                    rsp_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp0_result = rsp_result_reg[0];
    assign rsp1_result = rsp_result_reg[1];
    assign rsp0_zero   = rsp_zero_reg[0];
    assign rsp1_zero   = rsp_zero_reg[1];
    assign rsp0_err    = rsp_err_reg[0];
    assign rsp1_err    = rsp_err_reg[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a transaction-level model of arbitration and response buffering.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mv   [2];
    logic [31:0] mres [2];
    bit          mz   [2];
    bit          me   [2];
    bit          m_last;
    logic [1:0]  m_grant;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a * b;
            4'd10: return (b == 0) ? 32'd0 : a / b;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_bad(logic [3:0] op, logic [31:0] b);
        return !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12}) ||
               (op == 4'd10 && b == 0);
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        alu_result = ref_alu(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mres[i] = 0; mz[i] = 0; me[i] = 0;
        end
        m_last  = 1'b1;
        m_grant = 2'b00;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] op1, input logic [1:0] rr);
        req_valid = v;
        req0_a = a0; req0_b = b0; req0_op = op0;
        req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready = rr;
    endtask

    // One clock: check grant and ALU drive, clock, then check the buffers.
    task automatic step();
        logic [1:0]  elig, g;
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [3:0]  op [2];
        logic [31:0] ea, eb;
        logic [3:0]  eo;
        int s;
        #1;
        a[0] = req0_a; a[1] = req1_a; b[0] = req0_b; b[1] = req1_b;
        op[0] = req0_op; op[1] = req1_op;
        for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (!mv[i] || rsp_ready[i]);
        if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
        else               g = elig;
        s = g[1] ? 1 : 0;
        ea = 0; eb = 0; eo = 4'd2;
        if (g != 0 && !is_bad(op[s], b[s])) begin
            ea = a[s]; eb = b[s]; eo = op[s];
        end
        chk("req_ready", req_ready, g);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eo);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                mv[i] = 1;
                if (is_bad(op[i], b[i])) begin
                    mres[i] = 0; mz[i] = 1; me[i] = 1;
                end else begin
                    mres[i] = ref_alu(op[i], a[i], b[i]);
                    mz[i] = (mres[i] == 0); me[i] = 0;
                end
            end else if (rsp_ready[i]) begin
                mv[i] = 0;
            end
        end
        if (g != 0) m_last = g[1];
        m_grant = g;
        chk("rsp_valid", rsp_valid, {mv[1], mv[0]});
        chk("rsp0_result", rsp0_result, mres[0]);
        chk("rsp1_result", rsp1_result, mres[1]);
        chk("rsp0_zero", rsp0_zero, mz[0]);
        chk("rsp1_zero", rsp1_zero, mz[1]);
        chk("rsp0_err", rsp0_err, me[0]);
        chk("rsp1_err", rsp1_err, me[1]);
        $display("cycle t=%0t grant=%b rsp_valid=%b r0=%0h r1=%0h", $time, g, rsp_valid,
                 rsp0_result, rsp1_result);
    endtask

    initial begin
        logic [1:0]  v;
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic [3:0]  rop [2];

        rst_n = 1'b0;
        model_reset();
        drive(2'b00, 0, 0, 4'd2, 0, 0, 4'd2, 2'b00);
        #12;
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_rsp0_result", rsp0_result, 0);
        chk("reset_rsp1_err", rsp1_err, 0);
        req_valid = 2'b11;
        #1;
        chk("reset_req_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: add 5+7
        drive(2'b01, 5, 7, 4'd2, 0, 0, 4'd2, 2'b11);
        step();
        chk("add_result", rsp0_result, 32'd12);
        chk("add_valid", rsp_valid, 2'b01);

        // Ties alternate; requester 1 sub 9-9 gives zero
        drive(2'b11, 1, 2, 4'd2, 9, 9, 4'd6, 2'b11);
        for (int k = 0; k < 4; k++) step();
        chk("sub_zero", rsp1_zero, 1'b1);

        // Backpressure on requester 0
        drive(2'b00, 0, 0, 4'd2, 0, 0, 4'd2, 2'b11);
        step();
        drive(2'b01, 3, 4, 4'd2, 0, 0, 4'd2, 2'b00);
        step();
        drive(2'b11, 3, 4, 4'd2, 1, 1, 4'd0, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_only_req1", m_grant, 2'b10);
        end
        rsp_ready = 2'b11;
        step();
        chk("bp_release_req0", m_grant, 2'b01);

        // Error handling
        drive(2'b01, 100, 0, 4'd10, 0, 0, 4'd2, 2'b11);
        step();
        chk("div0_err", rsp0_err, 1'b1);
        chk("div0_zero", rsp0_zero, 1'b1);
        drive(2'b01, 5, 5, 4'd3, 0, 0, 4'd2, 2'b11);
        step();
        chk("illegal_err", rsp0_err, 1'b1);
        drive(2'b01, 100, 7, 4'd10, 0, 0, 4'd2, 2'b11);
        step();
        chk("div_result", rsp0_result, 32'd14);
        chk("div_err", rsp0_err, 1'b0);

        // Simultaneous drain and grant
        drive(2'b01, 5, 7, 4'd2, 0, 0, 4'd2, 2'b11);
        step();
        drive(2'b01, 6, 7, 4'd9, 0, 0, 4'd2, 2'b11);
        step();
        chk("drain_grant_valid", rsp_valid[0], 1'b1);
        chk("mul_result", rsp0_result, 32'd42);

        // Randomized traffic; a pending request is held until accepted
        ra[0] = 0; ra[1] = 0; rb[0] = 0; rb[1] = 0; rop[0] = 2; rop[1] = 2;
        v = 2'b00;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(v[i] && !m_grant[i])) begin
                    v[i]   = ($urandom_range(0, 3) != 0);
                    ra[i]  = $urandom;
                    rb[i]  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(0, 1000);
                    rop[i] = 4'($urandom_range(0, 15));
                end
            end
            drive(v, ra[0], rb[0], rop[0], ra[1], rb[1], rop[1],
                  2'($urandom_range(0, 3)));
            step();
        end

        // Asynchronous reset with both buffers full
        drive(2'b01, 1, 1, 4'd2, 0, 0, 4'd2, 2'b11);
        step();
        drive(2'b10, 0, 0, 4'd2, 2, 2, 4'd2, 2'b00);
        step();
        chk("pre_reset_valid", rsp_valid, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_rsp_valid", rsp_valid, 2'b00);
        chk("areset_rsp0_result", rsp0_result, 0);
        chk("areset_rsp1_result", rsp1_result, 0);
        chk("areset_rsp0_zero", rsp0_zero, 0);
        chk("areset_req_ready", req_ready, 2'b00);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(2'b11, 4, 4, 4'd2, 8, 8, 4'd2, 2'b11);
        step();
        chk("post_reset_tie", m_grant, 2'b01);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
